mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front-end directly upstream of the word-wide data RAM; the core's MEM stage issues byte/half/word loads and stores here.
- Drives the RAM's address, write-enable and write-data ports and consumes its combinational read data.
- Sub-word stores are read-modify-write because the RAM has only a whole-word write enable.
- Loads are sign- or zero-extended; misaligned or illegal accesses are flagged and never reach the RAM.

Parameters:
- ADDR_WIDTH, 32, byte address width; matches `ADDR_WIDTH.
- DATA_WIDTH, 32, word width; fixed at 32 (byte lanes 0..3).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted this cycle when req_valid_i & req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data; B uses [7:0], H uses [15:0].
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or illegal access; valid with rsp_valid_o.
- ram_addr_o  out  ADDR_WIDTH  byte address to RAM, with [1:0] forced to 0.
- ram_we_o  out  1  RAM write enable.
- ram_wdata_o  out  DATA_WIDTH  full word to RAM.
- ram_rdata_i  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- FSM states: IDLE, RD, WR, RSP. req_ready_o = (state==IDLE).
- IDLE: on accept, latch we, funct3, addr and wdata.
  - Error condition: H/HU with addr[0]!=0; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 BU/HU.
  - Error -> RSP with err=1.
  - Load, SB or SH -> RD.
  - SW -> WR.
- RD:
  - ram_addr_o = {addr_q[ADDR_WIDTH-1:2],2'b00}, ram_we_o = 0.
  - Capture ram_rdata_i into word_q at the clock edge.
  - Load: compute the extended result from word_q lane addr_q[1:0] into rsp_rdata, then -> RSP.
  - Store -> WR.
- Load extension: B/H sign-extend from bit 7/15 of the selected lane; BU/HU zero-extend; W passes through.
- WR:
  - ram_we_o = 1, same ram_addr_o.
  - ram_wdata_o: SW = wdata_q; SB/SH = word_q with the addressed lane(s) replaced by wdata_q[7:0] / wdata_q[15:0].
  - -> RSP.
- RSP: rsp_valid_o = 1 for exactly one cycle, then -> IDLE. No new accept during RSP.
- Outside WR: ram_we_o = 0 and ram_wdata_o = 0. Outside RD/WR: ram_addr_o = 0.
- Latency, counted from the accept cycle (A):
  - load: rsp_valid at A+2.
  - SW: write in A+1, rsp_valid at A+2.
  - SB/SH: read A+1, write A+2, rsp_valid at A+3.
  - error: rsp_valid at A+1, with no RAM access.
- Throughput: one request per 3-4 cycles; back-to-back requests are accepted in the cycle after RSP.
- Reset, in any state, including mid-RMW: state=IDLE, all latched registers 0, ram_we_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. An interrupted RMW performs no write.
- Request inputs outside the accept cycle are ignored.

Test Plan:
- Preload word 0x100 = 0x80817F02. LB 0x101 -> 0x0000007F; LB 0x102 -> 0xFFFFFF81; LBU 0x102 -> 0x00000081; rsp_valid 2 cycles after accept, err=0.
- Same word: LH 0x102 -> 0xFFFF8081; LHU 0x102 -> 0x00008081; LW 0x100 -> 0x80817F02.
- SB 0x103 with wdata 0x12345655 -> one ram_we_o pulse at A+2 carrying 0x55817F02; a following LW 0x100 returns 0x55817F02. SH 0x100 with wdata 0xAAAA1234 -> word becomes 0x80811234.
- LW 0x102, SH 0x101, and funct3=011 -> rsp_valid at A+1 with err=1, rdata=0, ram_we_o never asserted, memory unchanged.
- Back-to-back SW 0x104=0xDEADBEEF then LW 0x104 -> req_ready_o low during RD/WR/RSP; the load returns 0xDEADBEEF.
- Assert rst_i during WR of an SB -> no write occurs, outputs at reset values next cycle, word unchanged; a new request is accepted after reset deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide data RAM: sub-word stores are done as
// read-modify-write, loads are lane-selected and sign/zero extended.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  acc_err_c;
  logic [4:0]            rd_shift_c;
  logic [4:0]            wr_shift_c;
  logic [DATA_WIDTH-1:0] rd_lane_c;
  logic [DATA_WIDTH-1:0] load_ext_c;
  logic [DATA_WIDTH-1:0] lane_mask_c;
  logic [DATA_WIDTH-1:0] merged_c;

  // Illegal encodings, misalignment and unsigned store forms never reach the RAM.
  always_comb begin
    acc_err_c = 1'b0;
    if (req_funct3_i == 3'b011 || req_funct3_i == 3'b110 || req_funct3_i == 3'b111)
      acc_err_c = 1'b1;
    if ((req_funct3_i == F3_H || req_funct3_i == F3_HU) && req_addr_i[0])
      acc_err_c = 1'b1;
    if (req_funct3_i == F3_W && req_addr_i[1:0] != 2'b00)
      acc_err_c = 1'b1;
    if (req_we_i && (req_funct3_i == F3_BU || req_funct3_i == F3_HU))
      acc_err_c = 1'b1;
  end

  // Lane select and extension of the word being read this cycle.
  always_comb begin
    rd_shift_c = {addr_q[1:0], 3'b000};
    rd_lane_c  = ram_rdata_i >> rd_shift_c;
    case (funct3_q)
      F3_B:    load_ext_c = {{(DATA_WIDTH-8){rd_lane_c[7]}}, rd_lane_c[7:0]};
      F3_H:    load_ext_c = {{(DATA_WIDTH-16){rd_lane_c[15]}}, rd_lane_c[15:0]};
      F3_BU:   load_ext_c = DATA_WIDTH'(rd_lane_c[7:0]);
      F3_HU:   load_ext_c = DATA_WIDTH'(rd_lane_c[15:0]);
      default: load_ext_c = ram_rdata_i;
    endcase
  end

  // Sub-word store merge into the previously read word.
  always_comb begin
    wr_shift_c  = {addr_q[1:0], 3'b000};
    lane_mask_c = (funct3_q == F3_H) ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF);
    lane_mask_c = lane_mask_c << wr_shift_c;
    merged_c    = (word_q & ~lane_mask_c) |
                  ((DATA_WIDTH'(wdata_q[15:0]) << wr_shift_c) & lane_mask_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
          err_d    = acc_err_c;
          if (acc_err_c)                          state_d = S_RSP;
          else if (req_we_i && req_funct3_i == F3_W) state_d = S_WR;
          else                                    state_d = S_RD;
        end
      end
      S_RD: begin
        word_d = ram_rdata_i;
        if (we_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_ext_c;
          state_d = S_RSP;
        end
      end
      S_WR:    state_d = S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  // A reset arriving during WR suppresses the write at that same edge.
  assign req_ready_o = (state_q == S_IDLE);
  assign ram_addr_o  = (state_q == S_RD || state_q == S_WR) ?
                       {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign ram_we_o    = (state_q == S_WR) && !rst_i;
  assign ram_wdata_o = (state_q != S_WR) ? '0 :
                       (funct3_q == F3_W) ? wdata_q : merged_c;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_rdata_o = (state_q == S_RSP) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == S_RSP) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural word RAM and an
// expected-response queue.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wr;
    logic [31:0] wword;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[25];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_funct3_i(req_funct3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int          lat;
    int          nwr;
    int          wr_at;
    logic [31:0] wword;
    logic [31:0] waddr;
    logic        done;
    exp_t        e;
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.lat   = v.lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0; nwr = 0; wr_at = -1; done = 1'b0; wword = '0; waddr = '0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        nwr++;
        wr_at = lat;
        wword = ram_wdata;
        waddr = ram_addr;
      end
      if (rsp_valid) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " rdata"}, rsp_rdata, e.rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(e.err));
      end else begin
        check({tag, " ready while busy"}, 32'(req_ready), 32'd0);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no rsp_valid expected one within 8 cycles", tag);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
    check({tag, " write count"}, 32'(nwr), v.wr ? 32'd1 : 32'd0);
    if (v.wr) begin
      check({tag, " write cycle"}, 32'(wr_at), 32'(v.lat - 1));
      check({tag, " write data"}, wword, v.wword);
      check({tag, " write addr"}, waddr, {v.addr[31:2], 2'b00});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'h80817F02;

    //          we    f3      addr          wdata          rdata          err   lat wr    wword
    vecs[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,         32'h0000007F, 1'b0, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h102, 32'h0,         32'hFFFFFF81, 1'b0, 2, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h102, 32'h0,         32'h00000081, 1'b0, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,         32'hFFFF8081, 1'b0, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,         32'h00008081, 1'b0, 2, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h100, 32'h0,         32'h80817F02, 1'b0, 2, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'b000, 32'h103, 32'h0,         32'hFFFFFF80, 1'b0, 2, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h100, 32'h0,         32'h00007F02, 1'b0, 2, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h103, 32'h12345655,  32'h0,        1'b0, 3, 1'b1, 32'h55817F02};
    vecs[9]  = '{1'b0, 3'b010, 32'h100, 32'h0,         32'h55817F02, 1'b0, 2, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h100, 32'h80817F02,  32'h0,        1'b0, 2, 1'b1, 32'h80817F02};
    vecs[11] = '{1'b1, 3'b001, 32'h100, 32'hAAAA1234,  32'h0,        1'b0, 3, 1'b1, 32'h80811234};
    vecs[12] = '{1'b0, 3'b010, 32'h100, 32'h0,         32'h80811234, 1'b0, 2, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'b010, 32'h102, 32'h0,         32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 3'b001, 32'h101, 32'hFFFFFFFF,  32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 3'b011, 32'h100, 32'h0,         32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 3'b100, 32'h100, 32'hFFFFFFFF,  32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'b110, 32'h100, 32'h0,         32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 3'b111, 32'h100, 32'hFFFFFFFF,  32'h0,        1'b1, 1, 1'b0, 32'h0};
    vecs[19] = '{1'b0, 3'b010, 32'h100, 32'h0,         32'h80811234, 1'b0, 2, 1'b0, 32'h0};
    vecs[20] = '{1'b1, 3'b010, 32'h104, 32'hDEADBEEF,  32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};
    vecs[21] = '{1'b0, 3'b010, 32'h104, 32'h0,         32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0};
    vecs[22] = '{1'b1, 3'b001, 32'h106, 32'h1111CAFE,  32'h0,        1'b0, 3, 1'b1, 32'hCAFEBEEF};
    vecs[23] = '{1'b0, 3'b001, 32'h106, 32'h0,         32'hFFFFCAFE, 1'b0, 2, 1'b0, 32'h0};
    vecs[24] = '{1'b0, 3'b000, 32'h105, 32'h0,         32'hFFFFFFBE, 1'b0, 2, 1'b0, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check("reset ram_addr", ram_addr, 32'd0);
    check("reset ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    check("mem 0x100 after table", mem[8'h40], 32'h80811234);
    check("mem 0x104 after table", mem[8'h41], 32'hCAFEBEEF);

    // Reset while an SB sits in its write cycle: the write must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h100; req_wdata = 32'h000000FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw rd no write", 32'(ram_we), 32'd0);
    check("rmw rd addr", ram_addr, 32'h100);
    @(negedge clk);
    check("rmw wr pending", ram_wdata, 32'h808112FF);
    rst = 1'b1;
    #1;
    check("rmw wr suppressed", 32'(ram_we), 32'd0);
    @(negedge clk);
    check("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("post-reset rsp_err", 32'(rsp_err), 32'd0);
    check("post-reset rsp_rdata", rsp_rdata, 32'd0);
    check("post-reset ram_we", 32'(ram_we), 32'd0);
    check("post-reset ram_addr", ram_addr, 32'd0);
    check("post-reset ready", 32'(req_ready), 32'd1);
    check("post-reset mem", mem[8'h40], 32'h80811234);
    rst = 1'b0;
    run_req('{1'b0, 3'b010, 32'h100, 32'h0, 32'h80811234, 1'b0, 2, 1'b0, 32'h0}, "after reset");

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
